pipeline_hazard_ctrl: RTL

//  Central stall/flush controller for the 5-stage MIPS pipeline. Drives the enable/flush inputs of PC, IF/ID, ID/EX and EX/MEM.

---
 rtl/pipeline_hazard_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, branch/jump
// flushes, data-memory wait-state freezes, plus saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_jump,
    input  logic                  id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] id_ex_rt,
    input  logic                  branch_taken,
    input  logic                  ex_mem_access,
    input  logic                  cnt_clr,
    output logic                  pc_enable,
    output logic                  if_id_enable,
    output logic                  if_id_flush,
    output logic                  id_ex_enable,
    output logic                  id_ex_flush,
    output logic                  ex_mem_enable,
    output logic                  ex_mem_flush,
    output logic                  mem_wb_bubble,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
);

    typedef enum logic {S_RUN, S_WAIT} state_e;

    localparam bit               MULTI     = (MEM_LATENCY > 1);
    localparam int               WCW       = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;
    localparam logic [WCW-1:0]   WAIT_INIT = WCW'((MEM_LATENCY > 2) ? (MEM_LATENCY - 2) : 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_e           state_q, state_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             lu, frz, flush_ev;

    always_comb begin
        lu = id_ex_mem_read && (id_ex_rt != '0) &&
             ((id_uses_rs && (id_ex_rt == id_rs)) || (id_uses_rt && (id_ex_rt == id_rt)));
        frz = ((state_q == S_RUN) && ex_mem_access && MULTI) ||
              ((state_q == S_WAIT) && (wcnt_q != '0));
    end

    // Reset forces the idle pattern combinationally, so an abort mid-wait releases
    // the pipeline buffers without waiting for a clock edge.
    always_comb begin
        pc_enable     = 1'b1;
        if_id_enable  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_enable  = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_enable = 1'b1;
        ex_mem_flush  = 1'b0;
        mem_wb_bubble = 1'b0;
        flush_ev      = 1'b0;
        if (reset) begin
            if (frz) begin
                pc_enable     = 1'b0;
                if_id_enable  = 1'b0;
                id_ex_enable  = 1'b0;
                ex_mem_enable = 1'b0;
                mem_wb_bubble = 1'b1;
            end else if (branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                flush_ev     = 1'b1;
            end else if (lu) begin
                pc_enable    = 1'b0;
                if_id_enable = 1'b0;
                id_ex_flush  = 1'b1;
            end else if (id_jump) begin
                if_id_flush = 1'b1;
                flush_ev    = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_RUN: begin
                if (ex_mem_access && MULTI) begin
                    state_d = S_WAIT;
                    wcnt_d  = WAIT_INIT;
                end
            end
            S_WAIT: begin
                if (wcnt_q != '0) wcnt_d = wcnt_q - WCW'(1);
                else              state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (cnt_clr) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (!pc_enable && (stall_q != CNT_MAX)) stall_d = stall_q + CNT_W'(1);
            if (flush_ev && (flush_q != CNT_MAX))   flush_d = flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RUN;
            wcnt_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;

endmodule
